// File: rtl/mod241_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mod241_pkg
// Purpose  : Shared constants and state encoding for the mod-241 residue
//            accumulator stages of the mod-241 calculator.
// Revision : 1.0  initial release
// ============================================================================
package mod241_pkg;

  localparam int MOD   = 241;  // modulus
  localparam int MOD2  = 482;  // twice the modulus, for the second reduction step
  localparam int RES_W = 8;    // width of a residue / LUT output
  localparam int SUM_W = 9;    // width of an unreduced residue sum

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage : mod241_pkg
`default_nettype wire

// File: rtl/mod241_add_reduce.sv
`default_nettype none
// ============================================================================
// Module   : mod241_add_reduce
// Purpose  : Combinational 8+8 -> 8 modular adder. The running accumulator is
//            always 0..240 and a term is 0..255, so the raw sum is at most
//            495; subtracting 482 or 241 brings any such sum into 0..240.
// Revision : 1.0  initial release
// ============================================================================
module mod241_add_reduce
  import mod241_pkg::*;
(
  input  logic [RES_W-1:0] a_i,
  input  logic [RES_W-1:0] b_i,
  output logic [RES_W-1:0] sum_o
);

  localparam logic [SUM_W-1:0] c_mod  = SUM_W'(MOD);
  localparam logic [SUM_W-1:0] c_mod2 = SUM_W'(MOD2);

  logic [SUM_W-1:0] w_sum;
  logic [SUM_W-1:0] w_red;

  // Widen, add, then subtract the largest multiple of the modulus that fits.
  always_comb begin
    w_sum = {1'b0, a_i} + {1'b0, b_i};
    w_red = w_sum;
    if (w_sum >= c_mod2) begin
      w_red = w_sum - c_mod2;
    end else if (w_sum >= c_mod) begin
      w_red = w_sum - c_mod;
    end
    sum_o = RES_W'(w_red);
  end

endmodule : mod241_add_reduce
`default_nettype wire

// File: rtl/mod241_residue_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : mod241_residue_accumulator
// Purpose  : Accumulates a stream of per-chunk residues modulo 241 and emits
//            one reduced residue plus term count per frame over valid/ready.
// Revision : 1.0  initial release
// ============================================================================
module mod241_residue_accumulator
  import mod241_pkg::*;
#(
  parameter int NUM_TERMS = 84,
  parameter int CNT_W     = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RES_W-1:0] in_residue,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] out_residue,
  output logic [CNT_W-1:0] out_count
);

  // The counter must reach NUM_TERMS without wrapping.
  if ((1 << CNT_W) <= NUM_TERMS) begin : g_cnt_w_check
    $error("CNT_W too narrow for NUM_TERMS");
  end

  localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(NUM_TERMS);

  state_t           state_q, state_d;
  logic [RES_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RES_W-1:0] out_res_q, out_res_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic             in_ready_q;

  logic             w_accept;
  logic [RES_W-1:0] w_acc_op;
  logic [RES_W-1:0] w_sum;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_frame_end;

  // A frame always starts from zero, independent of any stale accumulator.
  assign w_acc_op    = (state_q == IDLE) ? '0 : acc_q;
  assign w_accept    = in_valid && in_ready_q;
  assign w_cnt_inc   = cnt_q + 1'b1;
  assign w_frame_end = in_last || (w_cnt_inc == c_last_cnt);

  mod241_add_reduce u_add_reduce (
    .a_i   (w_acc_op),
    .b_i   (in_residue),
    .sum_o (w_sum)
  );

  // Next-state and datapath updates; clr overrides every handshake.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    out_res_d = out_res_q;
    out_cnt_d = out_cnt_q;
    if (clr) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (w_accept) begin
            acc_d = w_sum;
            cnt_d = w_cnt_inc;
            if (w_frame_end) begin
              state_d   = DONE;
              out_res_d = w_sum;
              out_cnt_d = w_cnt_inc;
            end else begin
              state_d = ACCUM;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State registers; in_ready is registered so it stays low through reset
  // and only rises on the first edge after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      out_res_q  <= '0;
      out_cnt_q  <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      out_res_q  <= out_res_d;
      out_cnt_q  <= out_cnt_d;
      in_ready_q <= (state_d != DONE);
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = (state_q == DONE);
  assign out_residue = out_res_q;
  assign out_count   = out_cnt_q;

endmodule : mod241_residue_accumulator
`default_nettype wire

// File: tb/tb_mod241_residue_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_mod241_residue_accumulator
// Purpose  : Self-checking bench for mod241_residue_accumulator: directed
//            frames followed by random frames against a sum-mod-241 model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mod241_residue_accumulator;

  localparam int NUM_TERMS = 84;
  localparam int CNT_W     = 7;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             clr = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       in_residue = 8'd0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [7:0]       out_residue;
  logic [CNT_W-1:0] out_count;

  int tests  = 0;
  int failed = 0;

  mod241_residue_accumulator #(
    .NUM_TERMS (NUM_TERMS),
    .CNT_W     (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clr         (clr),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_residue  (in_residue),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_residue (out_residue),
    .out_count   (out_count)
  );

  always #5 clk = ~clk;

  // Watchdog so the run can never hang.
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one term and hold it until accepted (bounded wait).
  task automatic send(input logic [7:0] r, input logic l);
    int guard = 0;
    in_valid   = 1'b1;
    in_residue = r;
    in_last    = l;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) chk("send_timeout_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid   = 1'b0;
    in_last    = 1'b0;
    in_residue = 8'($urandom);
  endtask

  // Called one cycle after the last accept: result must already be valid.
  task automatic expect_result(input string tag, input int exp_res, input int exp_cnt,
                               input int hold, input bit check_hold);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_residue"}, 32'(out_residue), 32'(exp_res));
    chk({tag, "_count"}, 32'(out_count), 32'(exp_cnt));
    for (int i = 0; i < hold; i++) begin
      tick();
      if (check_hold) begin
        chk({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_hold_residue"}, 32'(out_residue), 32'(exp_res));
        chk({tag, "_hold_count"}, 32'(out_count), 32'(exp_cnt));
        chk({tag, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_in_ready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int exp_sum;
    int len;
    logic [7:0] r;
    logic lastflag;

    // ---- reset values ----
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_residue", 32'(out_residue), 32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rel_in_ready_before_edge", {31'd0, in_ready}, 32'd0);
    tick();
    chk("rel_in_ready_after_edge", {31'd0, in_ready}, 32'd1);

    // ---- two-term frame 240, 255 ----
    send(8'd240, 1'b0);
    chk("f2_no_early_valid", {31'd0, out_valid}, 32'd0);
    send(8'd255, 1'b1);
    expect_result("f2", 13, 2, 0, 1'b0);

    // ---- three-term frame, single-cycle out_valid ----
    send(8'd200, 1'b0);
    send(8'd100, 1'b0);
    send(8'd50, 1'b1);
    expect_result("f3", 109, 3, 0, 1'b0);

    // ---- full frame, in_last never asserted; ignored in_last while idle input ----
    for (int i = 0; i < NUM_TERMS; i++) begin
      if (i == 83) chk("full_no_valid_at_83", {31'd0, out_valid}, 32'd0);
      if (i == 40) begin
        in_last = 1'b1;  // in_valid low: must be ignored
        tick();
        in_last = 1'b0;
      end
      send(8'd255, 1'b0);
    end
    expect_result("full", 212, 84, 0, 1'b0);

    // ---- single-term frame with backpressure ----
    send(8'd241, 1'b1);
    expect_result("single_bp", 0, 1, 10, 1'b1);

    // ---- reset pulse mid-frame ----
    send(8'd100, 1'b0);
    send(8'd100, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_out_count", 32'(out_count), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    chk("midrst_in_ready_back", {31'd0, in_ready}, 32'd1);
    chk("midrst_no_output", {31'd0, out_valid}, 32'd0);
    send(8'd5, 1'b0);
    send(8'd7, 1'b1);
    expect_result("after_rst", 12, 2, 0, 1'b0);

    // ---- clr on the cycle of the last term's accept ----
    send(8'd50, 1'b0);
    in_valid   = 1'b1;
    in_residue = 8'd60;
    in_last    = 1'b1;
    clr        = 1'b1;
    tick();
    clr      = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("clr_last_no_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk("clr_last_no_valid_2", {31'd0, out_valid}, 32'd0);
    chk("clr_last_in_ready", {31'd0, in_ready}, 32'd1);
    send(8'd1, 1'b1);
    expect_result("after_clr", 1, 1, 0, 1'b0);

    // ---- clr against an output handshake in DONE ----
    send(8'd9, 1'b1);
    chk("clr_done_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    clr       = 1'b1;
    tick();
    out_ready = 1'b0;
    clr       = 1'b0;
    chk("clr_done_drop", {31'd0, out_valid}, 32'd0);
    chk("clr_done_in_ready", {31'd0, in_ready}, 32'd1);
    send(8'd3, 1'b1);
    expect_result("after_clr_done", 3, 1, 0, 1'b0);

    // ---- random frames vs. sum-mod-241 model ----
    for (int f = 0; f < 24; f++) begin
      len     = ($urandom_range(0, 3) == 0) ? NUM_TERMS : int'($urandom_range(1, 20));
      exp_sum = 0;
      for (int t = 0; t < len; t++) begin
        r        = 8'($urandom_range(0, 255));
        exp_sum += int'(r);
        if (t == len - 1)
          lastflag = (len == NUM_TERMS) ? 1'($urandom_range(0, 1)) : 1'b1;
        else
          lastflag = 1'b0;
        if ($urandom_range(0, 4) == 0) begin
          in_last    = 1'($urandom);
          in_residue = 8'($urandom);
          tick();
          in_last = 1'b0;
        end
        send(r, lastflag);
      end
      expect_result("rand", exp_sum % 241, len, int'($urandom_range(0, 3)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule : tb_mod241_residue_accumulator
`default_nettype wire
